mult3_seq: RTL and testbench



---
 rtl/mult3_seq.sv | 101 ++++++++++
 tb/tb_mult3_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult3_seq.sv
// Sequencer computing A*B*C (4-bit unsigned operands, 12-bit result) by
// reusing one external combinational 4x4 multiplier over three passes.
module mult3_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  input  logic [3:0]  in_c,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_p
);

  typedef enum logic [2:0] {
    IDLE,
    S_AB,
    S_LO,
    S_HI,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  a, b, c;
  logic [7:0]  ab;
  logic [7:0]  lo;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = 4'd0;
    mul_b     = 4'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_AB;
      end
      S_AB: begin
        mul_a     = a;
        mul_b     = b;
        state_nxt = S_LO;
      end
      S_LO: begin
        mul_a     = ab[3:0];
        mul_b     = c;
        state_nxt = S_HI;
      end
      S_HI: begin
        mul_a     = ab[7:4];
        mul_b     = c;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The high-nibble partial product carries weight 16, hence the 4-bit shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= 4'd0;
      b     <= 4'd0;
      c     <= 4'd0;
      ab    <= 8'd0;
      lo    <= 8'd0;
      out_p <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a <= in_a;
            b <= in_b;
            c <= in_c;
          end
        end
        S_AB:    ab    <= mul_p;
        S_LO:    lo    <= mul_p;
        S_HI:    out_p <= {4'b0000, lo} + {mul_p, 4'b0000};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult3_seq.sv
// Self-checking bench for mult3_seq: directed scenarios plus randomized
// transactions compared against plain-arithmetic expectations.
module tb_mult3_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a, in_b, in_c;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational multiplier.
  assign mul_p = mul_a * mul_b;

  mult3_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE; hold = cycles of out_ready=0 while in DONE.
  task automatic run_txn(input int a, input int b, input int c, input int hold);
    int ab, exp;
    ab  = a * b;
    exp = a * b * c;
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = 4'(a); in_b = 4'(b); in_c = 4'(c);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("ab_mul_a", mul_a, a);
    check("ab_mul_b", mul_b, b);
    check("ab_in_ready", in_ready, 0);
    check("ab_out_valid", out_valid, 0);
    step();
    check("lo_mul_a", mul_a, ab % 16);
    check("lo_mul_b", mul_b, c);
    check("lo_out_valid", out_valid, 0);
    step();
    check("hi_mul_a", mul_a, ab / 16);
    check("hi_mul_b", mul_b, c);
    check("hi_out_valid", out_valid, 0);
    step();
    check("done_out_valid", out_valid, 1);
    check("done_out_p", out_p, exp);
    check("done_mul_a", mul_a, 0);
    check("done_mul_b", mul_b, 0);
    for (int i = 0; i < hold; i++) begin
      // A competing operand offer while busy must be ignored.
      in_valid = 1'b1;
      in_a = 4'(a + 1); in_b = 4'(b + 1); in_c = 4'(c + 1);
      step();
      check("hold_out_valid", out_valid, 1);
      check("hold_out_p", out_p, exp);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_out_p", out_p, exp);
  endtask

  initial begin
    int ta[3] = '{1, 15, 7};
    int tb_[3] = '{1, 2, 7};
    int tc[3] = '{1, 3, 7};
    int exp_q[$];
    int idx, got, last_t, cyc;
    logic accept;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    #10 rst_n = 1'b1;
    step();

    // Directed: basic, max, zero operand, backpressure.
    run_txn(3, 5, 7, 0);
    run_txn(15, 15, 15, 0);
    run_txn(9, 0, 12, 0);
    run_txn(2, 4, 6, 10);
    step();
    check("bp_stay_idle", in_ready, 1);
    check("bp_idle_mul_a", mul_a, 0);

    // Back-to-back with in_valid and out_ready held high.
    idx = 0; got = 0; last_t = -1; cyc = 0;
    out_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      if (out_valid) begin
        check("b2b_out_p", out_p, exp_q.pop_front());
        if (last_t >= 0) check("b2b_interval", cyc - last_t, 5);
        last_t = cyc;
        got++;
      end
      accept = 1'b0;
      if (idx < 3) begin
        in_valid = 1'b1;
        in_a = 4'(ta[idx]); in_b = 4'(tb_[idx]); in_c = 4'(tc[idx]);
        if (in_ready) begin
          accept = 1'b1;
          exp_q.push_back(ta[idx] * tb_[idx] * tc[idx]);
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (accept) idx++;
      cyc++;
    end
    check("b2b_results_seen", got, 3);
    in_valid = 1'b0; out_ready = 1'b0;
    while (!in_ready && cyc < 80) begin step(); cyc++; end

    // Reset mid-operation, asserted between clock edges while in S_LO.
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5; in_c = 4'd7;
    step();
    in_valid = 1'b0;
    step();
    check("pre_rst_lo_mul_a", mul_a, 15);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_p", out_p, 0);
    check("midrst_mul_a", mul_a, 0);
    check("midrst_mul_b", mul_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("postrst_in_ready", in_ready, 1);
      check("postrst_out_valid", out_valid, 0);
    end
    run_txn(2, 3, 4, 1);

    // Randomized transactions against the arithmetic reference.
    for (int t = 0; t < 25; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check("gap_in_ready", in_ready, 1);
      end
      run_txn($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
